// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and owner choice for the fetch/data memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int WAIT_W   = 8;
  localparam int STARVE_W = 8;

  // Caller guarantees at least one request is present; fetch wins only when data is absent or fetch is starved.
  function automatic owner_e pick_owner(input logic d_req, input logic f_starved);
    return (d_req && !f_starved) ? OWN_D : OWN_F;
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// rtl/mem_arb_timeout.sv - memory wait counter with expiry, used only when MEM_ARB_TIMEOUT_EN is defined
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic in_busy,
  input  logic m_ack,
  output logic expire
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_ctr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_ctr <= '0;
    end else if (!in_busy) begin
      wait_ctr <= '0;
    end else if (!m_ack) begin
      wait_ctr <= wait_ctr + WAIT_W'(1);
    end
  end

  // Fires on the last unacknowledged BUSY cycle so the FSM leaves BUSY after exactly TIMEOUT cycles.
  assign expire = in_busy && !m_ack && (wait_ctr == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the single external memory port
// Optional wait timeout with sticky err is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_done,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          err
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_e                state;
  owner_e                owner;
  owner_e                pick;
  logic [STARVE_W-1:0]   starve_ctr;
  logic                  expire;
  logic [DW-1:0]         fill_data;

  assign pick = pick_owner(d_req, f_req && (starve_ctr == STARVE_LIM));
  // An aborted read returns all ones instead of whatever is on m_rdata.
  assign fill_data = m_ack ? m_rdata : '1;

`ifdef MEM_ARB_TIMEOUT_EN
  logic in_busy;
  assign in_busy = (state == BUSY);

  mem_arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .in_busy(in_busy),
    .m_ack  (m_ack),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (expire) begin
      err <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_F;
      starve_ctr <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      f_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      f_done     <= 1'b0;
      d_done     <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      f_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      f_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            state <= BUSY;
            busy  <= 1'b1;
            m_req <= 1'b1;
            owner <= pick;
            if (pick == OWN_D) begin
              d_gnt   <= 1'b1;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              if (f_req && (starve_ctr != STARVE_LIM)) begin
                starve_ctr <= starve_ctr + STARVE_W'(1);
              end
            end else begin
              f_gnt      <= 1'b1;
              m_we       <= 1'b0;
              m_addr     <= f_addr;
              m_wdata    <= '0;
              starve_ctr <= '0;
            end
          end
        end
        BUSY: begin
          if (m_ack || expire) begin
            state <= DONE;
            m_req <= 1'b0;
            m_we  <= 1'b0;
            if (owner == OWN_D) begin
              d_done <= 1'b1;
              if (!m_we) begin
                d_rdata <= fill_data;
              end
            end else begin
              f_done  <= 1'b1;
              f_rdata <= fill_data;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          m_req <= 1'b0;
          m_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
